scan_sequencer: RTL
===================

# scan_sequencer

Time-multiplexed scan controller that drives the select (`w[1:0]`) and enable (`en`) inputs of the team's 2-to-4 one-hot decoder. It steps through slot indices 0..`last`. Each slot has a blanking interval with `en` low, followed by a drive interval with `en` high, so one decoder output line is active at a time and never two in the same cycle. Typical use: digit-select for multiplexed 7-segment displays and LED matrices, placed directly upstream of the decoder.

## Interface
- `DIV_W`, 16: width of the drive-length input and of the internal slot counter.
- `BLANK`, 2: blanking cycles per slot with `en`=0. Legal range 0..2^DIV_W−1.
- `clk` input 1: the block's one clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `run` input 1: scanning request; level-sensitive.
- `div` input DIV_W: drive length minus one; each drive interval lasts `div`+1 cycles.
- `last` input 2: highest slot index scanned (active slots = `last`+1).
- `w` output 2: slot index, connects to the decoder select.
- `en` output 1: decoder enable; high only during drive intervals.
- `slot_start` output 1: one-cycle pulse on the first cycle of every slot.
- `frame_done` output 1: one-cycle pulse when the drive of slot `last` completes.

## Operation
- All outputs are registered. Reset values: `w`=0, `en`=0, `slot_start`=0, `frame_done`=0, state IDLE, counter 0.
- The FSM has three states: IDLE, BLANK and DRIVE.
- **IDLE:** `en`=0, `w`=0.
  - If `run`=1 and `BLANK`>0: go to BLANK with `slot_start`=1, counter=0, `w`=0.
  - If `run`=1 and `BLANK`=0: go to DRIVE directly with `slot_start`=1, counter=0, `w`=0.
- **BLANK:** `en`=0.
  - Counter increments each cycle.
  - When counter==`BLANK`−1: go to DRIVE, counter=0.
- **DRIVE:** `en`=1.
  - Counter increments until counter==`div_q`; that cycle is the slot end.
- **Slot end:** let nxt = `w`+1, or 0 if `w`≥`last`.
  - `frame_done`=1 if `w`≥`last`.
  - If `run`=1: enter the next slot with `w`=nxt, `slot_start`=1, counter=0. Next state is BLANK, or DRIVE if `BLANK`=0.
  - If `run`=0: go to IDLE with `w`=0, `en`=0.
- `div` is captured into `div_q` on every slot entry. Changes mid-slot affect only the next slot.
- `last` is sampled only at slot end. If it is lowered below the current `w`, the sequence wraps to 0 at that slot end and `frame_done` is asserted.
- `run` is sampled only in IDLE and at slot end. Deasserting it always completes the current slot; slots are never truncated.
- `w` changes only in cycles where `en`=0 is being registered, with one exception: `BLANK`=0. In that case `w` and `en`=1 update together and the decoder output moves directly from one line to the next.

## Timing
- Start latency: `run` sampled high at edge k gives `slot_start`=1 and `w`=0 visible after edge k. `en` rises after edge k+`BLANK`.
- Slot period = `BLANK`+`div`+1 cycles. `en` is high for `div`+1 consecutive cycles per slot.
- Frame period = (`last`+1)×(`BLANK`+`div`+1) cycles.
- `slot_start` and `frame_done` are high for exactly one cycle each. They coincide on the first cycle of slot 0 after a wrap.
- Stop at the end of slot `last`: the IDLE transition and `frame_done`=1 happen on the same edge.
- `rst_n`=0 at any edge forces the reset values on that edge, mid-slot included. Scanning restarts from slot 0 only after `rst_n`=1 and `run`=1.
- `div`=0 gives a one-cycle drive interval.
- `last`=0 scans slot 0 only, with `frame_done` asserted every slot.

## Test plan
- Free run with `BLANK`=2, `div`=3, `last`=3, `run`=1 held → `w` sequence 0,1,2,3,0. Each slot is 6 cycles: `en` 0,0,1,1,1,1. `frame_done` pulses every 24 cycles, coincident with `slot_start` at `w`=0.
- Stop mid-frame: `run` dropped during the drive of `w`=1 → slot 1 completes its full 4 `en` cycles, then `w`=0, `en`=0, IDLE. No `frame_done`.
- `last` lowered from 3 to 1 while `w`=2 → at slot-2 end, `w`=0 and `frame_done`=1. Subsequent frames run 0,1 with a 12-cycle period.
- `BLANK`=0, `div`=0, `last`=3 → `en` stays high constantly. `w` increments every cycle 0,1,2,3,0. `slot_start` is high every cycle.
- Reset mid-DRIVE (`w`=2, counter=1) with `rst_n`=0 for one edge → all outputs 0 after that edge. With `run`=1 held, the next edge gives `slot_start`=1, `w`=0.
- `div` changed from 3 to 7 mid-drive → current slot keeps 4 `en` cycles, next slot has 8.

Source files
------------

// File: rtl/scan_sequencer.sv
// Time-multiplexed scan controller for a 2-to-4 one-hot decoder.
// Each slot is a blanking interval (en low) followed by a drive interval (en high).
module scan_sequencer #(
    parameter int DIV_W = 16,
    parameter int BLANK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       last,
    output logic [1:0]       w,
    output logic             en,
    output logic             slot_start,
    output logic             frame_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam int               BLANK_M1  = (BLANK > 0) ? BLANK - 1 : 0;
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_M1);
    // With no blanking a slot opens straight into its drive interval.
    localparam logic [1:0]       ST_ENTRY  = (BLANK > 0) ? ST_BLANK : ST_DRIVE;

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;
    logic [1:0]       r_w;
    logic             r_en;
    logic             r_slot_start;
    logic             r_frame_done;

    logic [1:0]       w_state;
    logic [DIV_W-1:0] w_cnt;
    logic [DIV_W-1:0] w_div_q;
    logic [1:0]       w_w;
    logic             w_en;
    logic             w_slot_start;
    logic             w_frame_done;
    logic             w_slot_end;
    logic             w_wrap;
    logic [1:0]       w_nxt;

    assign w_slot_end = (r_state == ST_DRIVE) && (r_cnt == r_div_q);
    assign w_wrap     = (r_w >= last);
    assign w_nxt      = w_wrap ? 2'd0 : r_w + 2'd1;

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_div_q      = r_div_q;
        w_w          = r_w;
        w_slot_start = 1'b0;
        w_frame_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_w   = 2'd0;
                w_cnt = '0;
                if (run) begin
                    w_state      = ST_ENTRY;
                    w_slot_start = 1'b1;
                    w_div_q      = div;
                end
            end
            ST_BLANK: begin
                if (r_cnt == BLANK_END) begin
                    w_state = ST_DRIVE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (w_slot_end) begin
                    w_frame_done = w_wrap;
                    w_cnt        = '0;
                    if (run) begin
                        w_state      = ST_ENTRY;
                        w_w          = w_nxt;
                        w_slot_start = 1'b1;
                        w_div_q      = div;
                    end else begin
                        w_state = ST_IDLE;
                        w_w     = 2'd0;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_w     = 2'd0;
                w_cnt   = '0;
            end
        endcase
        w_en = (w_state == ST_DRIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_div_q      <= '0;
            r_w          <= 2'd0;
            r_en         <= 1'b0;
            r_slot_start <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_div_q      <= w_div_q;
            r_w          <= w_w;
            r_en         <= w_en;
            r_slot_start <= w_slot_start;
            r_frame_done <= w_frame_done;
        end
    end

    assign w          = r_w;
    assign en         = r_en;
    assign slot_start = r_slot_start;
    assign frame_done = r_frame_done;

endmodule
